uart_rx: RTL and testbench

//   8N1 UART receiver, LSB first: the receive side for the 8N1 transmitter already in the design.

---
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Two-flop input synchronizer, mid-bit sampling,
// framing-error strobe and line-break level detection.
module uart_rx #(
  parameter int CLK_FREQ  = 27_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       break_det,
  output logic       busy
);

  localparam int BAUD_COUNT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_COUNT = BAUD_COUNT / 2;
  localparam int CW         = $clog2(BAUD_COUNT);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_d;
  logic          rx_valid_d, frame_err_d, break_det_d;
  logic [1:0]    rst_sync;
  logic          rst_i;
  logic [1:0]    rx_sync;
  logic          rx_s;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i = rst_sync[1];

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], rx};
  end
  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
      frame_err <= frame_err_d;
      break_det <= break_det_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CW'(BAUD_COUNT - 1)) ? '0 : cnt_q + CW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    break_det_d = break_det;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CW'(HALF_COUNT - 1)) begin
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == CW'(BAUD_COUNT - 1)) begin
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
        if (cnt_q == CW'(BAUD_COUNT - 1)) begin
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            break_det_d = (shift_q == 8'h00);
            state_d     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) begin
          break_det_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: stimulus pushes expected events,
// a forked monitor pops and compares on each rx_valid / frame_err strobe.
module tb_uart_rx;

  localparam int BIT = 234;
  localparam int LAT = 2226;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, break_det, busy;

  uart_rx dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .break_det(break_det), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    bit         brk;
    int         t0;
    bit         chk;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int bl, input logic stop, input bit chk);
    exp_t e;
    e.is_err = !stop;
    e.data   = stop ? d : last_good;
    e.brk    = !stop && (d == 8'h00);
    e.t0     = cyc;
    e.chk    = chk;
    q.push_back(e);
    if (stop) last_good = d;
    rx = 1'b0;
    wait_cyc(bl);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(bl);
    end
    rx = stop;
    wait_cyc(bl);
    rx = 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && (rx_valid || frame_err)) begin
        check("valid_and_ferr_exclusive", int'(rx_valid && frame_err), 0);
        if (q.size() == 0) begin
          check("unexpected_strobe", int'(rx_valid) * 2 + int'(frame_err), 0);
        end else begin
          e = q.pop_front();
          check("strobe_kind_ferr", int'(frame_err), int'(e.is_err));
          check("rx_data", int'(rx_data), int'(e.data));
          if (e.is_err) check("break_det_at_ferr", int'(break_det), int'(e.brk));
          if (e.chk) check_range("latency", cyc - e.t0, LAT - 2, LAT + 2);
        end
      end
    end
  endtask

  initial begin
    int t0, t_fall, bl, gap;
    logic [7:0] d;
    fork
      monitor();
    join_none

    wait_cyc(5);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_valid", int'(rx_valid), 0);
    check("reset_ferr", int'(frame_err), 0);
    check("reset_break", int'(break_det), 0);
    check("reset_busy", int'(busy), 0);
    reset_n = 1'b1;
    wait_cyc(10);

    send_frame(8'hA5, BIT, 1'b1, 1'b1);
    wait_cyc(BIT);

    send_frame(8'h00, BIT, 1'b1, 1'b1);
    send_frame(8'hFF, BIT, 1'b1, 1'b1);
    send_frame(8'h55, BIT, 1'b1, 1'b1);
    wait_cyc(BIT);

    // Short glitch: busy must drop once the start re-sample sees high.
    t0 = cyc;
    rx = 1'b0;
    wait_cyc(50);
    rx = 1'b1;
    t_fall = -1;
    for (int i = 0; i < 400 && t_fall < 0; i++) begin
      @(negedge clk);
      if (!busy && cyc - t0 > 5) t_fall = cyc - t0;
    end
    check_range("glitch_busy_fall", t_fall, 117, 121);
    wait_cyc(BIT);

    send_frame(8'h3C, BIT, 1'b0, 1'b1);
    wait_cyc(4);
    check("break_after_3c", int'(break_det), 0);
    wait_cyc(2 * BIT);

    // Line break: 20 bit times low.
    begin
      exp_t e;
      e.is_err = 1'b1; e.data = last_good; e.brk = 1'b1; e.t0 = cyc; e.chk = 1'b1;
      q.push_back(e);
    end
    rx = 1'b0;
    wait_cyc(20 * BIT);
    check("break_held", int'(break_det), 1);
    check("break_busy", int'(busy), 1);
    rx = 1'b1;
    wait_cyc(4);
    check("break_cleared", int'(break_det), 0);
    check("break_idle", int'(busy), 0);
    wait_cyc(BIT);
    send_frame(8'h81, BIT, 1'b1, 1'b1);
    wait_cyc(BIT);

    // Reset during data bit 4 of 0x7E.
    d = 8'h7E;
    rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_cyc(BIT);
    end
    rx = d[4];
    wait_cyc(100);
    reset_n = 1'b0;
    #1;
    check("midrst_rx_data", int'(rx_data), 0);
    check("midrst_valid", int'(rx_valid), 0);
    check("midrst_ferr", int'(frame_err), 0);
    check("midrst_break", int'(break_det), 0);
    check("midrst_busy", int'(busy), 0);
    last_good = 8'h00;
    wait_cyc(20);
    rx = 1'b1;
    wait_cyc(300);
    reset_n = 1'b1;
    wait_cyc(10);
    send_frame(8'h42, BIT, 1'b1, 1'b1);
    wait_cyc(BIT);

    // Random bytes, random gaps, bit period within +/-3% of nominal.
    for (int n = 0; n < 14; n++) begin
      d   = 8'($urandom_range(0, 255));
      bl  = $urandom_range(0, 3) == 0 ? BIT : int'($urandom_range(227, 241));
      gap = $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(1, 300));
      send_frame(d, bl, 1'b1, bl == BIT);
      if (gap > 0) wait_cyc(gap);
    end
    wait_cyc(BIT);

    for (int i = 0; i < 5000 && q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
